dds_sweep_ctrl: RTL

//  Avalon-MM slave that sequences the 48-bit DDS frequency word for linear frequency sweeps.

---
 rtl/dds_sweep_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/dds_sweep_ctrl.sv
// Avalon-MM controlled linear frequency sweep sequencer feeding a DDS FREQW input.
// Word changes one clock after the triggering edge; readdata latency 1; slave never stalls.
module dds_sweep_ctrl #(
  parameter int FW  = 48,
  parameter int NPW = 16,
  parameter int DWW = 32
) (
  input  logic          csi_clk,
  input  logic          csi_reset_n,
  input  logic          avs_chipselect,
  input  logic [2:0]    avs_address,
  input  logic          avs_write,
  input  logic [31:0]   avs_writedata,
  input  logic          avs_read,
  output logic [31:0]   avs_readdata,
  output logic [FW-1:0] coe_freq_word,
  output logic          coe_freq_update,
  output logic          coe_busy,
  output logic          ins_irq
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [2:0] A_START_LO = 3'd0;
  localparam logic [2:0] A_START_HI = 3'd1;
  localparam logic [2:0] A_STEP_LO  = 3'd2;
  localparam logic [2:0] A_STEP_HI  = 3'd3;
  localparam logic [2:0] A_NPOINTS  = 3'd4;
  localparam logic [2:0] A_DWELL    = 3'd5;
  localparam logic [2:0] A_CTRL     = 3'd6;
  localparam logic [2:0] A_STATUS   = 3'd7;

  // Programmed configuration (CPU view)
  logic [FW-1:0]  start_cfg;
  logic [FW-1:0]  step_cfg;
  logic [NPW-1:0] npoints_cfg;
  logic [DWW-1:0] dwell_cfg;
  logic           cont;
  logic           irq_en;

  // Shadows of the configuration owned by the sweep in flight
  logic [FW-1:0]  sweep_start;
  logic [FW-1:0]  sweep_step;
  logic [NPW-1:0] sweep_n;
  logic [DWW-1:0] sweep_dwell;

  logic [0:0]     state;
  logic [NPW-1:0] idx;
  logic [DWW-1:0] dwell_cnt;
  logic           done;

  logic           wr_en;
  logic           rd_en;
  logic           ctrl_wr;
  logic           start_cmd;
  logic           stop_cmd;
  logic           clr_cmd;
  logic           launch;
  logic           dwell_hit;
  logic           last_point;
  logic           sweep_end;
  logic [DWW-1:0] launch_dwell;
  logic [DWW-1:0] reload_dwell;
  logic [31:0]    rd_mux;

  always_comb begin
    wr_en      = avs_chipselect & avs_write;
    rd_en      = avs_chipselect & avs_read;
    ctrl_wr    = wr_en && (avs_address == A_CTRL);
    start_cmd  = ctrl_wr & avs_writedata[0];
    stop_cmd   = ctrl_wr & avs_writedata[1];
    clr_cmd    = ctrl_wr & avs_writedata[2];
    // A zero dwell still holds every point for one clock
    launch_dwell = (dwell_cfg == '0) ? DWW'(1) : dwell_cfg;
    reload_dwell = (sweep_dwell == '0) ? DWW'(1) : sweep_dwell;
    launch     = (state == ST_IDLE) && start_cmd && !stop_cmd && (npoints_cfg != '0);
    dwell_hit  = (state == ST_RUN) && (dwell_cnt == DWW'(1));
    last_point = (idx == (sweep_n - NPW'(1)));
    sweep_end  = dwell_hit && last_point && !cont && !stop_cmd;
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      start_cfg   <= '0;
      step_cfg    <= '0;
      npoints_cfg <= '0;
      dwell_cfg   <= '0;
      cont        <= 1'b0;
      irq_en      <= 1'b0;
    end else if (wr_en) begin
      case (avs_address)
        A_START_LO: start_cfg[31:0]    <= avs_writedata;
        A_START_HI: start_cfg[FW-1:32] <= avs_writedata[FW-33:0];
        A_STEP_LO:  step_cfg[31:0]     <= avs_writedata;
        A_STEP_HI:  step_cfg[FW-1:32]  <= avs_writedata[FW-33:0];
        A_NPOINTS:  npoints_cfg        <= avs_writedata[NPW-1:0];
        A_DWELL:    dwell_cfg          <= avs_writedata[DWW-1:0];
        A_CTRL: begin
          cont   <= avs_writedata[3];
          irq_en <= avs_writedata[4];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      state           <= ST_IDLE;
      sweep_start     <= '0;
      sweep_step      <= '0;
      sweep_n         <= '0;
      sweep_dwell     <= '0;
      idx             <= '0;
      dwell_cnt       <= '0;
      coe_freq_word   <= '0;
      coe_freq_update <= 1'b0;
    end else begin
      coe_freq_update <= 1'b0;
      if (stop_cmd) begin
        state <= ST_IDLE;
      end else if (launch) begin
        sweep_start     <= start_cfg;
        sweep_step      <= step_cfg;
        sweep_n         <= npoints_cfg;
        sweep_dwell     <= dwell_cfg;
        coe_freq_word   <= start_cfg;
        coe_freq_update <= 1'b1;
        idx             <= '0;
        dwell_cnt       <= launch_dwell;
        state           <= ST_RUN;
      end else if (dwell_hit) begin
        if (!last_point) begin
          // Two's complement step: down-sweeps are plain modular adds
          coe_freq_word   <= coe_freq_word + sweep_step;
          coe_freq_update <= 1'b1;
          idx             <= idx + NPW'(1);
          dwell_cnt       <= reload_dwell;
        end else if (cont) begin
          coe_freq_word   <= sweep_start;
          coe_freq_update <= 1'b1;
          idx             <= '0;
          dwell_cnt       <= reload_dwell;
        end else begin
          state <= ST_IDLE;
        end
      end else if (state == ST_RUN) begin
        dwell_cnt <= dwell_cnt - DWW'(1);
      end
    end
  end

  // Sweep completion outranks a clear landing on the same edge
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      done <= 1'b0;
    end else if (sweep_end) begin
      done <= 1'b1;
    end else if (clr_cmd || launch) begin
      done <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      A_START_LO: rd_mux = start_cfg[31:0];
      A_START_HI: rd_mux[FW-33:0] = start_cfg[FW-1:32];
      A_STEP_LO:  rd_mux = step_cfg[31:0];
      A_STEP_HI:  rd_mux[FW-33:0] = step_cfg[FW-1:32];
      A_NPOINTS:  rd_mux[NPW-1:0] = npoints_cfg;
      A_DWELL:    rd_mux[DWW-1:0] = dwell_cfg;
      A_CTRL: begin
        rd_mux[3] = cont;
        rd_mux[4] = irq_en;
      end
      A_STATUS: begin
        rd_mux[0]        = (state == ST_RUN);
        rd_mux[1]        = done;
        rd_mux[2]        = cont;
        rd_mux[3]        = irq_en;
        rd_mux[16 +: NPW] = idx;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      avs_readdata <= '0;
    end else if (rd_en) begin
      avs_readdata <= rd_mux;
    end
  end

  assign coe_busy = (state == ST_RUN);
  assign ins_irq  = done & irq_en;

endmodule
